buzzer_scheduler: RTL and testbench



---
 rtl/buzzer_scheduler.sv | 104 ++++++++++
 tb/tb_buzzer_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/buzzer_scheduler.sv
// buzzer_scheduler: fixed-priority buzzer arbiter (goal > pad > wall) with play/gap timing.
// Optional BUZZER_GOAL_WARBLE_EN alternates goal/pad tones every WARBLE_TICKS during a goal sound.
module buzzer_scheduler #(
    parameter int WALL_TICKS   = 10,
    parameter int PAD_TICKS    = 20,
    parameter int GOAL_TICKS   = 100,
    parameter int GAP_TICKS    = 4,
    parameter int WARBLE_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_en,
    input  logic       pause,
    input  logic       req_wall,
    input  logic       req_pad,
    input  logic       req_goal,
    input  logic       tone_wall,
    input  logic       tone_pad,
    input  logic       tone_goal,
    output logic       buzzer,
    output logic [1:0] active,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
    localparam logic [7:0] WALL_LAST = 8'(WALL_TICKS - 1);
    localparam logic [7:0] PAD_LAST  = 8'(PAD_TICKS - 1);
    localparam logic [7:0] GOAL_LAST = 8'(GOAL_TICKS - 1);
    localparam logic [7:0] GAP_LAST  = GAP_TICKS == 0 ? 8'd0 : 8'(GAP_TICKS - 1);
    state_t     state;
    logic [2:0] pend;
    logic [7:0] cnt;
    logic [2:0] pend_eff;
    logic [1:0] hi;
    logic [3:0] hi_oh;
    logic [3:0] act_oh;
    logic [7:0] dur_last;
    logic       grant;
    logic       retrig;
    logic       goal_tone;
    logic       tone_sel;
    // Source ids double as priority ranks: wall 1, pad 2, goal 3; bit id-1 in pend.
    always_comb begin
        pend_eff = pend | {req_goal, req_pad, req_wall};
        hi       = pend_eff[2] ? 2'd3 : pend_eff[1] ? 2'd2 : pend_eff[0] ? 2'd1 : 2'd0;
        hi_oh    = 4'b0001 << hi;
        act_oh   = 4'b0001 << active;
        dur_last = active == 2'd3 ? GOAL_LAST : active == 2'd2 ? PAD_LAST : WALL_LAST;
        grant    = !pause && state != GAP && hi > active;
        retrig   = !pause && state == PLAY && !grant && |(pend_eff & act_oh[3:1]);
        tone_sel = active == 2'd3 ? goal_tone : active == 2'd2 ? tone_pad :
                   active == 2'd1 ? tone_wall : 1'b0;
    end
    assign busy = state != IDLE || |pend;
`ifdef BUZZER_GOAL_WARBLE_EN
    localparam logic [7:0] WARB_LAST = 8'(WARBLE_TICKS - 1);
    logic [7:0] wcnt;
    logic       wph;
    always_ff @(posedge clk) begin
        if (reset || grant || retrig) begin
            wcnt <= 8'd0;
            wph  <= 1'b0;
        end else if (!pause && state == PLAY && game_en && active == 2'd3) begin
            wcnt <= wcnt == WARB_LAST ? 8'd0 : wcnt + 8'd1;
            wph  <= wcnt == WARB_LAST ? ~wph : wph;
        end
    end
    assign goal_tone = wph ? tone_pad : tone_goal;
`else
    assign goal_tone = tone_goal;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pend   <= 3'd0;
            cnt    <= 8'd0;
            active <= 2'd0;
            buzzer <= 1'b0;
        end else begin
            buzzer <= state == PLAY && !pause && tone_sel;
            if (grant) begin
                state  <= PLAY;
                active <= hi;
                cnt    <= 8'd0;
                pend   <= pend_eff & ~hi_oh[3:1];
            end else if (retrig) begin
                cnt  <= 8'd0;
                pend <= pend_eff & ~act_oh[3:1];
            end else begin
                pend <= pend_eff;
                if (!pause && game_en && state == PLAY) begin
                    if (cnt == dur_last) begin
                        state  <= GAP_TICKS == 0 ? IDLE : GAP;
                        active <= 2'd0;
                        cnt    <= 8'd0;
                    end else
                        cnt <= cnt + 8'd1;
                end else if (!pause && game_en && state == GAP) begin
                    state <= cnt == GAP_LAST ? IDLE : GAP;
                    cnt   <= cnt == GAP_LAST ? 8'd0 : cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_buzzer_scheduler.sv
// tb_buzzer_scheduler: directed checks of grant order, timing, preemption, retrigger, pause, warble.
module tb_buzzer_scheduler;
    logic       clk = 0;
    logic       reset = 1;
    logic       game_en = 0;
    logic       pause = 0;
    logic       req_wall = 0;
    logic       req_pad = 0;
    logic       req_goal = 0;
    logic       tone_wall = 0;
    logic       tone_pad = 1;
    logic       tone_goal = 0;
    logic       buzzer;
    logic [1:0] active;
    logic       busy;
    int         n_cmp = 0;
    int         n_bad = 0;
    buzzer_scheduler dut (
        .clk(clk), .reset(reset), .game_en(game_en), .pause(pause),
        .req_wall(req_wall), .req_pad(req_pad), .req_goal(req_goal),
        .tone_wall(tone_wall), .tone_pad(tone_pad), .tone_goal(tone_goal),
        .buzzer(buzzer), .active(active), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            game_en = 1;
            cyc();
            game_en = 0;
            cyc();
        end
    endtask
    task automatic pulse(input logic w, input logic p, input logic g);
        req_wall = w;
        req_pad  = p;
        req_goal = g;
        cyc();
        {req_wall, req_pad, req_goal} = 3'b000;
    endtask
    initial begin
        cyc();
        cyc();
        reset = 0;
        check("rst_buzzer", buzzer, 0);
        check("rst_active", active, 0);
        check("rst_busy", busy, 0);
        // single pad sound
        pulse(0, 1, 0);
        check("pad_grant", active, 2);
        check("pad_busy", busy, 1);
        cyc();
        check("pad_tone_hi", buzzer, 1);
        tone_pad = 0;
        cyc();
        check("pad_tone_lo", buzzer, 0);
        tone_pad = 1;
        tick(19);
        check("pad_tick19", active, 2);
        tick(1);
        check("pad_end", active, 0);
        check("pad_gap_silent", buzzer, 0);
        tick(3);
        check("pad_gap_busy", busy, 1);
        tick(1);
        check("pad_idle_busy", busy, 0);
        // simultaneous wall + pad: pad first, wall after gap
        tone_wall = 1;
        pulse(1, 1, 0);
        check("dual_pad_first", active, 2);
        tick(20);
        check("dual_gap", active, 0);
        tick(4);
        check("dual_wall_next", active, 1);
        cyc();
        check("dual_wall_tone", buzzer, 1);
        tick(9);
        check("dual_wall_tick9", active, 1);
        tick(1);
        check("dual_wall_end", active, 0);
        tick(4);
        check("dual_idle", busy, 0);
        // goal preempts wall at tick 5
        pulse(1, 0, 0);
        tick(5);
        pulse(0, 0, 1);
        check("preempt_goal", active, 3);
        tick(99);
        check("preempt_goal_tick99", active, 3);
        tick(1);
        check("preempt_goal_end", active, 0);
        tick(4);
        check("preempt_no_resume", active, 0);
        check("preempt_idle", busy, 0);
        // pad retrigger at tick 7 plus wall queued
        pulse(0, 1, 0);
        tick(7);
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        tick(19);
        check("retrig_tick26", active, 2);
        tick(1);
        check("retrig_end", active, 0);
        check("retrig_wall_pend", busy, 1);
        tick(4);
        check("retrig_wall_plays", active, 1);
        tick(10);
        tick(4);
        check("retrig_idle", busy, 0);
        // pause with goal request latched
        pulse(0, 1, 0);
        tick(10);
        pause = 1;
        cyc();
        check("pause_silent", buzzer, 0);
        tick(25);
        pulse(0, 0, 1);
        tick(25);
        check("pause_held", active, 2);
        check("pause_buzzer", buzzer, 0);
        pause = 0;
        cyc();
        check("pause_goal_preempt", active, 3);
        tick(100);
        check("pause_goal_end", active, 0);
        tick(4);
        check("pause_idle", busy, 0);
        // goal tone selection, then reset mid-sound
        tone_goal = 1;
        tone_pad  = 0;
        pulse(0, 0, 1);
        cyc();
        check("warble_phase0", buzzer, 1);
        tick(8);
`ifdef BUZZER_GOAL_WARBLE_EN
        check("warble_phase1", buzzer, 0);
`else
        check("warble_phase1", buzzer, 1);
`endif
        tick(8);
        check("warble_phase2", buzzer, 1);
        tick(14);
        reset = 1;
        cyc();
        reset = 0;
        check("midrst_buzzer", buzzer, 0);
        check("midrst_active", active, 0);
        check("midrst_busy", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
